// File: rtl/serial_addsub_ovf.sv
// Bit-serial two's-complement add/subtract with carry-out and signed overflow, LSB first.
// Latency: START at edge t0 -> DONE high in the cycle after edge t0+WIDTH.
// Backpressure: none; START is ignored outside IDLE, and S/CO/OVF hold until the next result.
//
// Ports:
//   CLK    clock, rising edge
//   nRST   synchronous active-low reset
//   START  request an operation (sampled in IDLE only)
//   SUB    0 = add, 1 = subtract (sampled with START)
//   A, B   WIDTH-bit two's-complement operands (sampled with START)
//   BUSY   high while bits are being processed
//   DONE   one-cycle pulse in the cycle after S/CO/OVF were updated
//   S      WIDTH-bit result, held between operations
//   CO     carry out of the MSB (subtract: 1 = no borrow)
//   OVF    signed overflow (carry into MSB XOR carry out of MSB)
module serial_addsub_ovf #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;     // operand A, consumed from bit 0
    logic [WIDTH-1:0] b_sh;     // operand B (already inverted for subtract)
    logic [WIDTH-1:0] sum_sh;   // partial sum, new bits enter at the MSB
    logic             carry;    // carry into the bit currently being processed
    logic [CW-1:0]    count;    // index of the bit currently being processed

    logic             s_bit;
    logic             c_nxt;
    logic             last_bit;

    // one full-adder slice
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit = (count == LAST);

    // state register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and status outputs
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (last_bit) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                // result registers were loaded on the edge that entered FIN
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // serial datapath and result registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            S      <= '0;
            CO     <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        // subtract as A + ~B + 1: invert B here, inject the +1 as carry-in
                        a_sh   <= A;
                        b_sh   <= B ^ {WIDTH{SUB}};
                        carry  <= SUB;
                        count  <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_nxt;
                    sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
                    count  <= count + CW'(1);
                    if (last_bit) begin
                        // 'carry' here is the carry into the MSB; c_nxt is the carry out of it
                        S   <= {s_bit, sum_sh[WIDTH-1:1]};
                        CO  <= c_nxt;
                        OVF <= carry ^ c_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ovf.sv
module tb_serial_addsub_ovf;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    serial_addsub_ovf #(.WIDTH(W)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .START(start),
        .SUB  (sub),
        .A    (a),
        .B    (b),
        .BUSY (busy),
        .DONE (done),
        .S    (s),
        .CO   (co),
        .OVF  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic ref_model(input int ua, input int ub, input bit sb,
                             output logic [W-1:0] rs, output logic rco, output logic rovf);
        int sa;
        int sbv;
        int u;
        int r;
        sa  = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sbv = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        if (!sb) begin
            u   = ua + ub;
            rco = (u >= (1 << W));
            r   = sa + sbv;
        end else begin
            u   = ua - ub + (1 << W);
            rco = (ua >= ub);
            r   = sa - sbv;
        end
        rs   = W'(u % (1 << W));
        rovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 20) begin
            tick();
            n++;
        end
        check("idle_wait", {30'd0, busy, done}, 32'd0);
    endtask

    // Full operation: START accepted at t0, checks every cycle through t0+W+1.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tsub, input logic [W-1:0] es, input logic eco, input logic eovf);
        logic [W-1:0] s_prev;
        wait_idle();
        s_prev = s;
        a     = ta;
        b     = tb_;
        sub   = tsub;
        start = 1'b1;
        tick();                       // edge t0
        start = 1'b0;
        a     = W'($urandom);         // late operand changes must not matter
        b     = W'($urandom);
        sub   = 1'($urandom);
        for (int k = 1; k < W; k++) begin
            tick();
            check({tag, " busy_run"}, busy, 1);
            check({tag, " done_run"}, done, 0);
            check({tag, " s_hold"}, s, s_prev);
        end
        tick();                       // edge t0+W: DONE cycle
        check({tag, " done"}, done, 1);
        check({tag, " busy_fin"}, busy, 0);
        check({tag, " s"}, s, es);
        check({tag, " co"}, co, eco);
        check({tag, " ovf"}, ovf, eovf);
        tick();
        check({tag, " done_clr"}, done, 0);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rco;
        logic         rovf;
        int           ndone;

        nrst  = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst s", s, 0);
        check("rst co", co, 0);
        check("rst ovf", ovf, 0);
        nrst = 1'b1;
        tick();

        // directed arithmetic cases
        run_op("add_basic", 4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0);
        run_op("add_ovf",   4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op("add_neg",   4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
        run_op("sub_basic", 4'b0010, 4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0);
        run_op("sub_ovf",   4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);

        // START during RUN and during FIN is ignored
        wait_idle();
        ndone = 0;
        a = 4'b0001; b = 4'b0001; sub = 1'b0; start = 1'b1;
        tick();                       // t0
        start = 1'b0;
        tick();                       // t0+1
        a = 4'b0111; start = 1'b1;
        tick();                       // t0+2: START sampled in RUN
        start = 1'b0;
        tick();                       // t0+3
        check("ign busy_t3", busy, 1);
        tick();                       // t0+4
        check("ign done", done, 1);
        check("ign s", s, 4'b0010);
        start = 1'b1;                 // pulse during the FIN cycle
        ndone += int'(done);
        tick();                       // t0+5
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("ign no_restart", busy, 0);
            ndone += int'(done);
            tick();
        end
        check("ign one_done", ndone, 1);
        check("ign s_hold", s, 4'b0010);

        // reset after two bits aborts the operation
        a = 4'b0101; b = 4'b0010; sub = 1'b0; start = 1'b1;
        tick();                       // t0
        start = 1'b0;
        tick();
        tick();                       // two bits processed
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort s", s, 0);
        check("abort co", co, 0);
        check("abort ovf", ovf, 0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            ndone += int'(done) + int'(busy);
            tick();
        end
        check("abort quiet", ndone, 0);
        run_op("after_abort", 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);

        // exhaustive sweep
        for (int ia = 0; ia < (1 << W); ia++) begin
            for (int ib = 0; ib < (1 << W); ib++) begin
                for (int is = 0; is < 2; is++) begin
                    ref_model(ia, ib, 1'(is), rs, rco, rovf);
                    run_op("sweep", W'(ia), W'(ib), 1'(is), rs, rco, rovf);
                end
            end
        end

        // random operations
        for (int n = 0; n < 40; n++) begin
            int ra;
            int rb;
            bit rsub;
            ra   = int'($urandom_range((1 << W) - 1, 0));
            rb   = int'($urandom_range((1 << W) - 1, 0));
            rsub = 1'($urandom);
            ref_model(ra, rb, rsub, rs, rco, rovf);
            run_op("rand", W'(ra), W'(rb), rsub, rs, rco, rovf);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
